// File: rtl/alib_sqrt_pkg.sv
// alib_sqrt_pkg: shared definitions for the iterative square-root unit.
// Holds the FSM state encoding, the root-width derivation and the
// iteration-counter width helper used by alib_sqrt_iter.
package alib_sqrt_pkg;

  // FSM states, fixed 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } sqrt_state_e;

  // Root width: integer half of the radicand plus fractional bits.
  function automatic int unsigned out_w_f(input int unsigned in_w,
                                          input int unsigned frac_w);
    return (in_w / 2) + frac_w;
  endfunction

  // Counter width clog2(out_w), kept at least one bit wide for out_w == 1.
  function automatic int unsigned cnt_w_f(input int unsigned out_w);
    return (out_w > 1) ? $clog2(out_w) : 1;
  endfunction

endpackage

// File: rtl/alib_sqrt_step.sv
// alib_sqrt_step: one combinational digit step of the restoring square root.
// Ports:
//   rem_i    partial remainder (OUT_W+2 bits, always < 2^OUT_W on entry)
//   root_i   partial root
//   pair_i   next radicand bit pair, MSB pair first
//   rem_c_o  remainder after this step
//   root_c_o root after this step
module alib_sqrt_step #(
  parameter  int unsigned OUT_W = 16,
  localparam int unsigned REM_W = OUT_W + 2
) (
  input  logic [REM_W-1:0] rem_i,
  input  logic [OUT_W-1:0] root_i,
  input  logic [1:0]       pair_i,
  output logic [REM_W-1:0] rem_c_o,
  output logic [OUT_W-1:0] root_c_o
);

  logic [REM_W-1:0] rem_sh_c;
  logic [REM_W-1:0] trial_c;
  logic             ge_c;

  // The incoming remainder never exceeds 2*root < 2^OUT_W, so dropping its
  // top two bits in the shift loses nothing.
  always_comb begin
    rem_sh_c = REM_W'({rem_i, pair_i});
    trial_c  = {root_i, 2'b01};
    ge_c     = (rem_sh_c >= trial_c);
    rem_c_o  = ge_c ? (rem_sh_c - trial_c) : rem_sh_c;
    root_c_o = (root_i << 1) | OUT_W'(ge_c);
  end

endmodule

// File: rtl/alib_sqrt_iter.sv
// alib_sqrt_iter: sequential integer square root, one result bit per clock.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready radicand handshake (in_ready high only in IDLE)
//   in_data           unsigned radicand, IN_W bits
//   out_valid/out_ready result handshake (held until taken)
//   out_root          root with FRAC_W fractional bits, optionally rounded
//   out_rem           floor remainder X - floor_root^2
//   out_exact         remainder is zero
module alib_sqrt_iter
  import alib_sqrt_pkg::*;
#(
  parameter  int unsigned IN_W   = 32,
  parameter  int unsigned FRAC_W = 0,
  parameter  int unsigned ROUND  = 0,
  localparam int unsigned OUT_W  = out_w_f(IN_W, FRAC_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_root,
  output logic [OUT_W:0]   out_rem,
  output logic             out_exact
);

  localparam int unsigned X_W   = 2 * OUT_W;
  localparam int unsigned REM_W = OUT_W + 2;
  localparam int unsigned CNT_W = cnt_w_f(OUT_W);
  localparam logic [OUT_W-1:0] ROOT_MAX = '1;

  // Elaboration-time parameter checks.
  if (((IN_W % 2) != 0) || (IN_W < 2)) begin : g_bad_in_w
    $error("alib_sqrt_iter: IN_W must be even and >= 2");
  end
  if (FRAC_W > (IN_W / 2)) begin : g_bad_frac_w
    $error("alib_sqrt_iter: FRAC_W must be in 0..IN_W/2");
  end
  if (ROUND > 1) begin : g_bad_round
    $error("alib_sqrt_iter: ROUND must be 0 or 1");
  end

  sqrt_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [OUT_W-1:0] root_q, root_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_root_q, out_root_d;
  logic [OUT_W:0]   out_rem_q, out_rem_d;
  logic             out_exact_q, out_exact_d;

  logic [REM_W-1:0] step_rem_c;
  logic [OUT_W-1:0] step_root_c;
  logic             round_up_c;

  // Single shared digit step fed by the top bit pair of the shifting radicand.
  alib_sqrt_step #(.OUT_W(OUT_W)) u_step (
    .rem_i    (rem_q),
    .root_i   (root_q),
    .pair_i   (x_q[X_W-1 -: 2]),
    .rem_c_o  (step_rem_c),
    .root_c_o (step_root_c)
  );

  // Round up when X - r^2 > r; never past the all-ones root.
  assign round_up_c = (ROUND != 0) &&
                      (step_rem_c > REM_W'(step_root_c)) &&
                      (step_root_c != ROOT_MAX);

  // Next-state and output-register logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    rem_d       = rem_q;
    root_d      = root_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_root_d  = out_root_q;
    out_rem_d   = out_rem_q;
    out_exact_d = out_exact_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          x_d        = X_W'(in_data) << (2 * FRAC_W);
          rem_d      = '0;
          root_d     = '0;
          cnt_d      = CNT_W'(OUT_W - 1);
          in_ready_d = 1'b0;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        x_d    = x_q << 2;
        rem_d  = step_rem_c;
        root_d = step_root_c;
        if (cnt_q == '0) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          out_root_d  = step_root_c + OUT_W'(round_up_c);
          out_rem_d   = (OUT_W + 1)'(step_rem_c);
          out_exact_d = (step_rem_c == '0);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_root_q  <= '0;
      out_rem_q   <= '0;
      out_exact_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      rem_q       <= rem_d;
      root_q      <= root_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_root_q  <= out_root_d;
      out_rem_q   <= out_rem_d;
      out_exact_q <= out_exact_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_root  = out_root_q;
  assign out_rem   = out_rem_q;
  assign out_exact = out_exact_q;

endmodule

// File: tb/tb_alib_sqrt_iter.sv
// tb_alib_sqrt_iter: three configurations (floor, round, 8 fractional bits)
// driven with the same radicands and compared against an arithmetic model.
module tb_alib_sqrt_iter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        ready_f, valid_f, exact_f;
  logic [15:0] root_f;
  logic [16:0] rem_f;
  logic        ready_r, valid_r, exact_r;
  logic [15:0] root_r;
  logic [16:0] rem_r;
  logic        ready_q, valid_q, exact_q;
  logic [23:0] root_q;
  logic [24:0] rem_q;

  int n_asserts = 0;
  int n_fail    = 0;

  alib_sqrt_iter #(.IN_W(32), .FRAC_W(0), .ROUND(0)) u_floor (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready_f),
    .in_data(in_data), .out_valid(valid_f), .out_ready(out_ready),
    .out_root(root_f), .out_rem(rem_f), .out_exact(exact_f)
  );

  alib_sqrt_iter #(.IN_W(32), .FRAC_W(0), .ROUND(1)) u_round (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready_r),
    .in_data(in_data), .out_valid(valid_r), .out_ready(out_ready),
    .out_root(root_r), .out_rem(rem_r), .out_exact(exact_r)
  );

  alib_sqrt_iter #(.IN_W(32), .FRAC_W(8), .ROUND(0)) u_frac (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready_q),
    .in_data(in_data), .out_valid(valid_q), .out_ready(out_ready),
    .out_root(root_q), .out_rem(rem_q), .out_exact(exact_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Reference: largest r with r*r <= x, then round to nearest if asked
  // (x closer to (r+1)^2 means 4x > (2r+1)^2), capped at the width limit.
  function automatic void ref_sqrt(input longint unsigned x, input int out_w,
                                   input bit rnd,
                                   output longint unsigned root,
                                   output longint unsigned rem);
    longint unsigned r, t;
    r = 0;
    for (int b = out_w - 1; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= x) r = t;
    end
    rem  = x - r * r;
    root = r;
    if (rnd && (4 * x > (2 * r + 1) * (2 * r + 1)) && (r != (64'd1 << out_w) - 1))
      root = r + 1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_results(input logic [31:0] d, input string tag);
    longint unsigned er, em;
    ref_sqrt(64'(d), 16, 1'b0, er, em);
    check({tag, " floor.root"},  64'(root_f), er);
    check({tag, " floor.rem"},   64'(rem_f), em);
    check({tag, " floor.exact"}, 64'(exact_f), 64'(em == 0));
    ref_sqrt(64'(d), 16, 1'b1, er, em);
    check({tag, " round.root"},  64'(root_r), er);
    check({tag, " round.rem"},   64'(rem_r), em);
    check({tag, " round.exact"}, 64'(exact_r), 64'(em == 0));
    ref_sqrt(64'(d) << 16, 24, 1'b0, er, em);
    check({tag, " frac.root"},   64'(root_q), er);
    check({tag, " frac.rem"},    64'(rem_q), em);
    check({tag, " frac.exact"},  64'(exact_q), 64'(em == 0));
  endtask

  // Offer one radicand to all three units once they are all idle.
  task automatic accept(input logic [31:0] d);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!(ready_f && ready_r && ready_q) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("ready before accept", 64'(ready_f & ready_r & ready_q), 64'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    check("in_ready low after accept", 64'({ready_f, ready_r, ready_q}), 64'd0);
  endtask

  // Wait (bounded) for all results and check the exact latencies.
  task automatic wait_done();
    int lat_f, lat_r, lat_q;
    lat_f = -1; lat_r = -1; lat_q = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (valid_f && lat_f < 0) lat_f = k;
      if (valid_r && lat_r < 0) lat_r = k;
      if (valid_q && lat_q < 0) lat_q = k;
      if (lat_f >= 0 && lat_r >= 0 && lat_q >= 0) break;
    end
    check("latency floor", 64'(lat_f), 64'd16);
    check("latency round", 64'(lat_r), 64'd16);
    check("latency frac",  64'(lat_q), 64'd24);
  endtask

  // One-cycle out_ready pulse; all units must be idle the next cycle.
  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid low after transfer", 64'({valid_f, valid_r, valid_q}), 64'd0);
    check("in_ready high after transfer", 64'({ready_f, ready_r, ready_q}), 64'd7);
  endtask

  task automatic run_op(input logic [31:0] d, input string tag);
    accept(d);
    wait_done();
    check_results(d, tag);
  endtask

  initial begin
    logic [31:0] d;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset in_ready",  64'({ready_f, ready_r, ready_q}), 64'd7);
    check("reset out_valid", 64'({valid_f, valid_r, valid_q}), 64'd0);
    check("reset root",      64'(root_f) | 64'(root_r) | 64'(root_q), 64'd0);
    check("reset rem",       64'(rem_f) | 64'(rem_r) | 64'(rem_q), 64'd0);
    check("reset exact",     64'({exact_f, exact_r, exact_q}), 64'd0);
    rst_n = 1'b1;

    run_op(32'd17, "d17");
    check("d17 literal root", 64'(root_f), 64'd4);
    check("d17 literal rem",  64'(rem_f), 64'd1);
    release_out();
    run_op(32'd0, "d0");
    check("d0 literal exact", 64'(exact_f), 64'd1);
    release_out();
    run_op(32'hFFFF_FFFF, "dmax");
    check("dmax literal rem",        64'(rem_f), 64'd131070);
    check("dmax round saturates",    64'(root_r), 64'd65535);
    release_out();
    run_op(32'd20, "d20");
    check("d20 round root", 64'(root_r), 64'd4);
    release_out();
    run_op(32'd21, "d21");
    check("d21 round root", 64'(root_r), 64'd5);
    release_out();
    run_op(32'd2, "d2");
    check("d2 frac root", 64'(root_q), 64'd362);
    release_out();
    run_op(32'd4, "d4");
    check("d4 frac root", 64'(root_q), 64'd512);
    release_out();

    for (int i = 0; i < 16; i++) begin
      d = (i < 6) ? 32'($urandom_range(0, 2000)) : $urandom;
      run_op(d, $sformatf("rand%0d", i));
      release_out();
    end

    // Backpressure: results hold and a new offer is ignored.
    d = $urandom;
    run_op(d, "bp");
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      @(negedge clk);
      check("bp in_ready low",  64'({ready_f, ready_r, ready_q}), 64'd0);
      check("bp out_valid high", 64'({valid_f, valid_r, valid_q}), 64'd7);
      check_results(d, "bp hold");
    end
    in_valid = 1'b0;
    release_out();

    // Reset mid-operation aborts and clears outputs immediately.
    accept(32'd1000);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort out_valid", 64'({valid_f, valid_r, valid_q}), 64'd0);
    check("abort in_ready",  64'({ready_f, ready_r, ready_q}), 64'd7);
    check("abort root",      64'(root_f), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd144, "d144");
    check("d144 literal root",  64'(root_f), 64'd12);
    check("d144 literal exact", 64'(exact_f), 64'd1);
    release_out();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
